// File: rtl/echo_pkg.sv
// Shared definitions for the multi-mode echo processor: mode and fill-state encodings,
// default converter offsets and the saturating adder used by the echo arithmetic.
package echo_pkg;

    typedef enum logic [1:0] {
        MODE_BYP = 2'b00,
        MODE_FF  = 2'b01,
        MODE_FBS = 2'b10,
        MODE_FBA = 2'b11
    } mode_e;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_e;

    localparam int         DW_DEF         = 10;
    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'd200;

    // Adds two sign-extended operands and clamps the sum to the signed range of w bits.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Circular delay-line storage: DEPTH x DW simple dual-port RAM, synchronous read and write.
module echo_delay_ram
    import echo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/processor_echo_multi.sv
// Echo processor between ADC and DAC: strobe detection, two-stage sample pipeline,
// fill/run priming FSM, write pointer and saturating echo arithmetic around echo_delay_ram.
module processor_echo_multi
    import echo_pkg::*;
#(
    parameter int            DW         = DW_DEF,
    parameter int            AW         = 10,
    parameter logic [DW-1:0] ADC_OFFSET = ADC_OFFSET_DEF,
    parameter logic [DW-1:0] DAC_OFFSET = DAC_OFFSET_DEF
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          data_valid,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] delay_sel,
    input  logic [2:0]    gain_shift,
    input  logic [1:0]    mode,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          primed,
    output logic          overrun
);

    logic                 dv_q;
    logic                 vld_p1_q, vld_p1_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;
    fill_state_e          state_q, state_d;
    logic [AW-1:0]        wp_q, wp_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        dly_q, dly_d;
    logic [DW-1:0]        data_out_q, data_out_d;

    logic signed [DW-1:0] x_p1_q, x_p1_d;
    mode_e                mode_p1_q, mode_p1_d;
    logic [2:0]           gain_p1_q, gain_p1_d;
    logic [AW-1:0]        dsel_p1_q, dsel_p1_d;

    logic                 s_stb, busy, accept;
    logic [AW-1:0]        dsel_eff, rd_addr;
    logic [DW-1:0]        rd_data, wr_data, y_sat;
    logic                 dly_change, echo_en;
    fill_state_e          fill_st;
    logic [AW-1:0]        fill_cnt;
    logic signed [DW-1:0] d_p1, echo_p1;
    logic signed [31:0]   x_ext, e_ext;

    // Stage 0: strobe detection and sample capture. A sample stays in flight until its
    // output pulse has retired, which enforces the three-cycle minimum strobe spacing.
    always_comb begin
        dsel_eff = (delay_sel == '0) ? AW'(1) : delay_sel;
        s_stb    = data_valid & ~dv_q;
        busy     = vld_p1_q | out_valid_q;
        accept   = s_stb & ~busy;
        rd_addr  = wp_q - dsel_eff;
    end

    always_comb begin
        x_p1_d    = x_p1_q;
        mode_p1_d = mode_p1_q;
        gain_p1_d = gain_p1_q;
        dsel_p1_d = dsel_p1_q;
        if (accept) begin
            x_p1_d    = signed'(data_in - ADC_OFFSET);
            mode_p1_d = mode_e'(mode);
            gain_p1_d = gain_shift;
            dsel_p1_d = dsel_eff;
        end
    end

    echo_delay_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (sysclk),
        .we    (vld_p1_q),
        .waddr (wp_q),
        .wdata (wr_data),
        .re    (accept),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Stage 1: echo arithmetic. Buffer data is masked until the line is primed at the
    // currently latched delay, so stale samples are never replayed after a delay change.
    always_comb begin
        dly_change = (dsel_p1_q != dly_q);
        echo_en    = ~dly_change && (state_q == ST_RUN) && (cnt_q >= dly_q);
        d_p1       = echo_en ? signed'(rd_data) : '0;
        echo_p1    = d_p1 >>> gain_p1_q;
        x_ext      = {{(32-DW){x_p1_q[DW-1]}}, x_p1_q};
        e_ext      = {{(32-DW){echo_p1[DW-1]}}, echo_p1};
        case (mode_p1_q)
            MODE_BYP: e_ext = '0;
            MODE_FBS: e_ext = -e_ext;
            default:  ;
        endcase
        y_sat   = DW'(sat_add(x_ext, e_ext, DW));
        wr_data = (mode_p1_q == MODE_BYP || mode_p1_q == MODE_FF) ? x_p1_q : y_sat;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        wp_d        = wp_q;
        data_out_d  = data_out_q;
        fill_st     = state_q;
        fill_cnt    = cnt_q;
        vld_p1_d    = accept;
        out_valid_d = vld_p1_q;
        overrun_d   = overrun_q | (s_stb & busy);
        if (vld_p1_q) begin
            wp_d       = wp_q + AW'(1);
            data_out_d = y_sat + DAC_OFFSET;
            if (dly_change) begin
                dly_d    = dsel_p1_q;
                fill_st  = ST_FILL;
                fill_cnt = '0;
            end
            // The sample written at this edge counts toward priming at the new delay.
            if (fill_st == ST_FILL) begin
                cnt_d   = fill_cnt + AW'(1);
                state_d = (cnt_d >= dly_d) ? ST_RUN : ST_FILL;
            end else begin
                cnt_d   = fill_cnt;
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q        <= 1'b0;
            vld_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            state_q     <= ST_FILL;
            wp_q        <= '0;
            cnt_q       <= '0;
            dly_q       <= AW'(1);
            data_out_q  <= DAC_OFFSET;
        end else begin
            dv_q        <= data_valid;
            vld_p1_q    <= vld_p1_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            data_out_q  <= data_out_d;
        end
    end

    always_ff @(posedge sysclk) begin
        x_p1_q    <= x_p1_d;
        mode_p1_q <= mode_p1_d;
        gain_p1_q <= gain_p1_d;
        dsel_p1_q <= dsel_p1_d;
    end

    // Stage 2: registered outputs.
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign primed    = (state_q == ST_RUN);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_processor_echo_multi.sv
// Directed bench for processor_echo_multi: a sample-indexed reference model feeds a
// scoreboard queue per instance (AW=10 and AW=4) that is drained on out_valid.
module tb_processor_echo_multi;

    logic        clk;
    logic        rst_n;
    logic        dv_a, dv_b;
    logic [9:0]  din_a, din_b;
    logic [9:0]  dsel_a;
    logic [3:0]  dsel_b;
    logic [2:0]  gain_a, gain_b;
    logic [1:0]  mode_a, mode_b;
    logic [9:0]  dout_a, dout_b;
    logic        ov_a, ov_b, pr_a, pr_b, orun_a, orun_b;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    int          m_hist[256];
    int          m_n, m_seg, m_dly;

    processor_echo_multi #(.DW(10), .AW(10)) dut_a (
        .sysclk     (clk),
        .rst_n      (rst_n),
        .data_valid (dv_a),
        .data_in    (din_a),
        .delay_sel  (dsel_a),
        .gain_shift (gain_a),
        .mode       (mode_a),
        .data_out   (dout_a),
        .out_valid  (ov_a),
        .primed     (pr_a),
        .overrun    (orun_a)
    );

    processor_echo_multi #(.DW(10), .AW(4)) dut_b (
        .sysclk     (clk),
        .rst_n      (rst_n),
        .data_valid (dv_b),
        .data_in    (din_b),
        .delay_sel  (dsel_b),
        .gain_shift (gain_b),
        .mode       (mode_b),
        .data_out   (dout_b),
        .out_valid  (ov_b),
        .primed     (pr_b),
        .overrun    (orun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_n   = 0;
        m_seg = 0;
        m_dly = -1;
    endfunction

    // Reference behaviour indexed by sample number; returns the signed saturated y.
    function automatic int model_step(input int raw, input int dsel, input int gain, input int mode);
        int x, d, e, y, dd;
        x = (raw - 385) & 1023;
        if (x >= 512) x -= 1024;
        dd = (dsel == 0) ? 1 : dsel;
        if (dd != m_dly) begin
            m_dly = dd;
            m_seg = m_n;
        end
        d = (m_n - m_seg >= dd) ? m_hist[m_n - dd] : 0;
        e = d >>> gain;
        if (mode == 0)      y = x;
        else if (mode == 2) y = x - e;
        else                y = x + e;
        if (y > 511)  y = 511;
        if (y < -512) y = -512;
        m_hist[m_n] = (mode < 2) ? x : y;
        m_n++;
        return y;
    endfunction

    function automatic logic model_primed();
        return (m_n - m_seg) >= m_dly;
    endfunction

    always @(negedge clk) begin
        if (ov_a === 1'b1) begin
            check("a_expected_pending", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) check("a_data_out", dout_a, exp_a.pop_front());
        end
        if (ov_b === 1'b1) begin
            check("b_expected_pending", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) check("b_data_out", dout_b, exp_b.pop_front());
        end
    end

    task automatic send(input bit inst_b, input int raw, input int dsel, input int gain, input int mode);
        int y;
        y = model_step(raw, dsel, gain, mode);
        @(negedge clk);
        if (!inst_b) begin
            din_a = 10'(raw); dsel_a = 10'(dsel); gain_a = 3'(gain); mode_a = 2'(mode);
            dv_a  = 1'b1;
            exp_a.push_back(32'((y + 200) & 1023));
        end else begin
            din_b = 10'(raw); dsel_b = 4'(dsel); gain_b = 3'(gain); mode_b = 2'(mode);
            dv_b  = 1'b1;
            exp_b.push_back(32'((y + 200) & 1023));
        end
        @(negedge clk);
        check("no_early_valid", inst_b ? ov_b : ov_a, 0);
        dv_a = 1'b0;
        dv_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("single_pulse", inst_b ? ov_b : ov_a, 0);
        check(inst_b ? "b_primed" : "a_primed", inst_b ? pr_b : pr_a, model_primed());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dv_a  = 1'b0;
        dv_b  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out_a", dout_a, 200);
        check("rst_out_valid_a", ov_a, 0);
        check("rst_primed_a", pr_a, 0);
        check("rst_overrun_a", orun_a, 0);
        check("rst_data_out_b", dout_b, 200);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        dv_a = 1'b0; din_a = '0; dsel_a = 10'd1; gain_a = '0; mode_a = '0;
        dv_b = 1'b0; din_b = '0; dsel_b = 4'd1;  gain_b = '0; mode_b = '0;
        model_reset();

        // Bypass
        do_reset();
        send(0, 'h186, 4, 0, 0);
        check("t1_bypass", dout_a, 205);

        // Subtractive feedback impulse response
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            send(0, (k == 0) ? 485 : 385, 4, 1, 2);
            case (k)
                0:  check("t2_y0", dout_a, 300);
                2:  check("t2_unprimed", pr_a, 0);
                3:  check("t2_primed", pr_a, 1);
                4:  check("t2_y4", dout_a, 150);
                8:  check("t2_y8", dout_a, 225);
                12: check("t2_y12", dout_a, 188);
                16: check("t2_y16", dout_a, 206);
                default: ;
            endcase
        end

        // Additive feedback saturation
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send(0, 785, 1, 0, 3);
            check("t3_sat", dout_a, (k == 0) ? 600 : 711);
        end

        // Re-prime on delay change 4 -> 2
        do_reset();
        for (int k = 0; k < 14; k++) begin
            send(0, 388 + 10 * k, (k < 8) ? 4 : 2, 0, 1);
            if (k == 8) check("t4_primed_drop", pr_a, 0);
            if (k == 9) check("t4_masked", dout_a, 293);
            if (k == 10) check("t4_new_delay", dout_a, 386);
        end

        // Strobe spacing abuse and sticky overrun
        do_reset();
        exp_a.push_back(32'((model_step(392, 1, 0, 0) + 200) & 1023));
        @(negedge clk);
        din_a = 10'd392; dsel_a = 10'd1; gain_a = '0; mode_a = '0; dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        @(negedge clk);
        din_a = 10'd500; dv_a = 1'b1;
        @(negedge clk);
        dv_a = 1'b0;
        check("t6_overrun_set", orun_a, 1);
        repeat (3) @(negedge clk);
        check("t6_dropped_hold", dout_a, 207);
        send(0, 405, 1, 0, 0);
        check("t6_overrun_sticky", orun_a, 1);

        // Reset asserted while a sample is in flight
        @(negedge clk);
        din_a = 10'd600; dv_a = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data_out", dout_a, 200);
        check("t6_rst_out_valid", ov_a, 0);
        check("t6_rst_overrun", orun_a, 0);
        dv_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_rst_no_pulse", ov_a, 0);
        end
        rst_n = 1'b1;
        model_reset();

        // Wrap across pointer rollover on the AW=4 instance
        do_reset();
        for (int k = 0; k < 40; k++) begin
            send(1, 385 + k, 15, 0, 1);
            if (k >= 15) check("t5_ramp", dout_b, 2 * k - 15 + 200);
        end

        repeat (2) @(negedge clk);
        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
